// File: rtl/multi_stage_sync_filter.sv
// Per-bit clock-domain-crossing synchronizer with a consecutive-sample glitch filter
// and registered one-cycle rise/fall event pulses for independent asynchronous level inputs.
module multi_stage_sync_filter #(
    parameter int             N       = 8,
    parameter int             STAGES  = 2,
    parameter int             FILT    = 3,
    parameter logic [N-1:0]   RST_VAL = {N{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  dataIn,
    output logic [N-1:0]  dataOut,
    output logic [N-1:0]  risePulse,
    output logic [N-1:0]  fallPulse,
    output logic          anyChange
);

    // A single-sample filter still needs a one-bit counter that simply stays at zero.
    localparam int              CW       = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILT - 1);

    logic [N-1:0]   sync_r [STAGES];
    logic [N-1:0]   syncd_s;
    logic [CW-1:0]  cnt_r [N];
    logic [CW-1:0]  cnt_nxt_s [N];
    logic [N-1:0]   out_nxt_s;
    logic [N-1:0]   rise_nxt_s;
    logic [N-1:0]   fall_nxt_s;

    assign syncd_s = sync_r[STAGES-1];

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_r[s] <= RST_VAL;
            end
        end else begin
            sync_r[0] <= dataIn;
            for (int s = 1; s < STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Filter next state: a change is accepted on the FILT-th consecutive mismatching sample.
    always_comb begin
        out_nxt_s = dataOut;
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i] = {CW{1'b0}};
            if (syncd_s[i] == dataOut[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] >= CNT_LAST) begin
                out_nxt_s[i] = syncd_s[i];
                cnt_nxt_s[i] = {CW{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
        rise_nxt_s = ~dataOut & out_nxt_s;
        fall_nxt_s = dataOut & ~out_nxt_s;
    end

    // Filtered level, counters and event pulses, all updated on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut   <= RST_VAL;
            risePulse <= {N{1'b0}};
            fallPulse <= {N{1'b0}};
            anyChange <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            dataOut   <= out_nxt_s;
            risePulse <= rise_nxt_s;
            fallPulse <= fall_nxt_s;
            anyChange <= |(rise_nxt_s | fall_nxt_s);
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_stage_sync_filter.sv
// Bench for multi_stage_sync_filter: directed scenarios on two configurations plus
// randomized inputs compared against a run-length reference model of the filter.
module tb_multi_stage_sync_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din1, dout1, rise1, fall1;
    logic       any1;
    logic [7:0] din2, dout2, rise2, fall2;
    logic       any2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_stage_sync_filter #(.N(8), .STAGES(2), .FILT(3), .RST_VAL(8'h00)) dut1 (
        .clk(clk), .rst(rst), .dataIn(din1), .dataOut(dout1),
        .risePulse(rise1), .fallPulse(fall1), .anyChange(any1)
    );

    multi_stage_sync_filter #(.N(8), .STAGES(3), .FILT(1), .RST_VAL(8'h00)) dut2 (
        .clk(clk), .rst(rst), .dataIn(din2), .dataOut(dout2),
        .risePulse(rise2), .fallPulse(fall2), .anyChange(any2)
    );

    // Reference model: dataOut follows the input sample seen STAGES edges ago once that
    // differs from dataOut for FILT consecutive edges.
    localparam int STG [2] = '{2, 3};
    localparam int FLT [2] = '{3, 1};
    logic [7:0] m_hist [2][4];
    int         m_run  [2][8];
    logic [7:0] m_out  [2];
    logic [7:0] m_rise [2];
    logic [7:0] m_fall [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) m_hist[d][k] = 8'h00;
            for (int b = 0; b < 8; b++) m_run[d][b] = 0;
            m_out[d]  = 8'h00;
            m_rise[d] = 8'h00;
            m_fall[d] = 8'h00;
        end
    endtask

    task automatic model_edge(input logic [7:0] a, input logic [7:0] b2);
        logic [7:0] seen;
        logic [7:0] nin;
        for (int d = 0; d < 2; d++) begin
            nin  = (d == 0) ? a : b2;
            seen = m_hist[d][STG[d]-1];
            for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
            m_hist[d][0] = nin;
            m_rise[d] = 8'h00;
            m_fall[d] = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (seen[b] !== m_out[d][b]) begin
                    m_run[d][b] = m_run[d][b] + 1;
                    if (m_run[d][b] == FLT[d]) begin
                        m_run[d][b] = 0;
                        if (seen[b]) m_rise[d][b] = 1'b1;
                        else         m_fall[d][b] = 1'b1;
                        m_out[d][b] = seen[b];
                    end
                end else begin
                    m_run[d][b] = 0;
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] e1, r1, e2, r2;
        rst  = 1'b0;
        din1 = 8'hFF;
        din2 = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({dout1, rise1, fall1, any1, dout2, rise2, fall2, any2} !== 50'h0) begin
                errors++;
                $display("FAIL reset_hold got d1=%h r1=%h f1=%h d2=%h r2=%h exp all 0",
                         dout1, rise1, fall1, dout2, rise2);
            end
            din1 = ~din1;
            din2 = ~din2;
        end
        din1 = 8'hFF;
        din2 = 8'hFF;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e1 = (k >= 5) ? 8'hFF : 8'h00;
            r1 = (k == 5) ? 8'hFF : 8'h00;
            e2 = (k >= 4) ? 8'hFF : 8'h00;
            r2 = (k == 4) ? 8'hFF : 8'h00;
            checks++;
            if (dout1 !== e1 || rise1 !== r1 || fall1 !== 8'h00 || any1 !== (k == 5)) begin
                errors++;
                $display("FAIL reset_release1 k=%0d got d=%h r=%h f=%h a=%b exp d=%h r=%h",
                         k, dout1, rise1, fall1, any1, e1, r1);
            end
            checks++;
            if (dout2 !== e2 || rise2 !== r2 || fall2 !== 8'h00 || any2 !== (k == 4)) begin
                errors++;
                $display("FAIL reset_release2 k=%0d got d=%h r=%h f=%h a=%b exp d=%h r=%h",
                         k, dout2, rise2, fall2, any2, e2, r2);
            end
        end
        din1 = 8'h00;
        din2 = 8'h00;
        step(8);
    endtask

    task automatic test_rise();
        din1 = 8'hA5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (dout1 !== ((k >= 5) ? 8'hA5 : 8'h00) || rise1 !== ((k == 5) ? 8'hA5 : 8'h00) ||
                fall1 !== 8'h00 || any1 !== (k == 5)) begin
                errors++;
                $display("FAIL rise_latency k=%0d got d=%h r=%h f=%h a=%b exp d=%h",
                         k, dout1, rise1, fall1, any1, (k >= 5) ? 8'hA5 : 8'h00);
            end
        end
        din1 = 8'h00;
        step(8);
    endtask

    task automatic test_glitch();
        int rise_at, fall_at, nr, nf;
        din1 = 8'h01;
        step(2);
        din1 = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (dout1 !== 8'h00 || rise1 !== 8'h00 || fall1 !== 8'h00 || any1 !== 1'b0) begin
                errors++;
                $display("FAIL glitch_short got d=%h r=%h f=%h a=%b exp all 0",
                         dout1, rise1, fall1, any1);
            end
        end
        rise_at = 0; fall_at = 0; nr = 0; nf = 0;
        din1 = 8'h01;
        for (int s = 1; s <= 15; s++) begin
            @(negedge clk);
            if (s == 3) din1 = 8'h00;
            if (rise1 != 8'h00) begin nr++; rise_at = s; end
            if (fall1 != 8'h00) begin nf++; fall_at = s; end
        end
        checks++;
        if (nr != 1 || nf != 1 || rise_at != 5 || fall_at != 8) begin
            errors++;
            $display("FAIL glitch_accept got rises=%0d@%0d falls=%0d@%0d exp 1@5 1@8",
                     nr, rise_at, nf, fall_at);
        end
    endtask

    task automatic test_simultaneous();
        int nany;
        din1 = 8'h80;
        step(8);
        nany = 0;
        din1 = 8'h02;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (any1) nany++;
            if (k == 5) begin
                checks++;
                if (rise1 !== 8'h02 || fall1 !== 8'h80 || any1 !== 1'b1 || dout1 !== 8'h02) begin
                    errors++;
                    $display("FAIL simul_pulse got d=%h r=%h f=%h a=%b exp d=02 r=02 f=80 a=1",
                             dout1, rise1, fall1, any1);
                end
            end
        end
        checks++;
        if (nany != 1) begin
            errors++;
            $display("FAIL simul_any_count got %0d exp 1", nany);
        end
        din1 = 8'h00;
        step(8);
    endtask

    task automatic test_reset_mid_filter();
        din1 = 8'hF0;
        step(8);
        checks++;
        if (dout1 !== 8'hF0) begin
            errors++;
            $display("FAIL midrst_setup got %h exp f0", dout1);
        end
        din1 = 8'h0F;
        step(4);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (dout1 !== 8'h00 || rise1 !== 8'h00 || fall1 !== 8'h00 || any1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_immediate got d=%h r=%h f=%h a=%b exp all 0",
                     dout1, rise1, fall1, any1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (dout1 !== ((k >= 5) ? 8'h0F : 8'h00) || rise1 !== ((k == 5) ? 8'h0F : 8'h00) ||
                fall1 !== 8'h00) begin
                errors++;
                $display("FAIL midrst_restart k=%0d got d=%h r=%h f=%h exp d=%h",
                         k, dout1, rise1, fall1, (k >= 5) ? 8'h0F : 8'h00);
            end
        end
        din1 = 8'h00;
        step(8);
    endtask

    task automatic test_stages3_nofilter();
        din2 = 8'h08;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (dout2 !== ((k >= 4) ? 8'h08 : 8'h00) || rise2 !== ((k == 4) ? 8'h08 : 8'h00) ||
                any2 !== (k == 4)) begin
                errors++;
                $display("FAIL s3f1_step k=%0d got d=%h r=%h a=%b exp d=%h",
                         k, dout2, rise2, any2, (k >= 4) ? 8'h08 : 8'h00);
            end
        end
        din2 = 8'h00;
        step(6);
    endtask

    task automatic test_random();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            din1 = din1 ^ 8'($urandom & $urandom);
            din2 = din2 ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end else begin
                model_edge(din1, din2);
                @(negedge clk);
            end
            checks++;
            if (dout1 !== m_out[0] || rise1 !== m_rise[0] || fall1 !== m_fall[0] ||
                any1 !== |(m_rise[0] | m_fall[0])) begin
                errors++;
                $display("FAIL random1 cyc=%0d got d=%h r=%h f=%h a=%b exp d=%h r=%h f=%h",
                         i, dout1, rise1, fall1, any1, m_out[0], m_rise[0], m_fall[0]);
            end
            checks++;
            if (dout2 !== m_out[1] || rise2 !== m_rise[1] || fall2 !== m_fall[1] ||
                any2 !== |(m_rise[1] | m_fall[1])) begin
                errors++;
                $display("FAIL random2 cyc=%0d got d=%h r=%h f=%h a=%b exp d=%h r=%h f=%h",
                         i, dout2, rise2, fall2, any2, m_out[1], m_rise[1], m_fall[1]);
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        din1 = 8'h00;
        din2 = 8'h00;
        test_reset();
        test_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid_filter();
        test_stages3_nofilter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
